program_memory_arb: RTL and testbench

Shared instruction store serving MEM_NUM_CHANNELS fetch requesters (one per core's fetcher) from a single-port array. Host loads the program over a dedicated write port. After reset the block self-clears the array in a sweep state, then services one read or one write per cycle. Requester access order is round-robin, and writes take priority over reads. It sits between the per-core fetch units and the host/DCR load path, and succeeds the single-channel program memory.

---
 rtl/prog_mem_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/program_memory_arb.sv | 141 ++++++++++++++
 tb/tb_program_memory_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and helpers for the multi-channel program memory.
//   pm_state_t : CLEAR while the array is swept to zero after reset, RUN afterwards.
//   slice_lo() : low bit of a channel's slice inside a flat per-channel vector.
package prog_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } pm_state_t;

    function automatic int unsigned slice_lo(input int unsigned chan, input int unsigned width);
        return chan * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search for a requester starts at ptr_i
// and wraps; the first requesting channel found wins. The pointer register
// itself is owned by the parent.
//   req_i       : request vector, one bit per channel
//   ptr_i       : highest-priority channel this cycle
//   grant_o     : one-hot grant (all zero when nothing requests)
//   grant_idx_o : index of the granted channel
//   any_grant_o : some channel was granted
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_grant_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr_i) + i) % N);
            if (!any_grant_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                any_grant_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/program_memory_arb.sv
// Shared instruction store for MEM_NUM_CHANNELS fetchers plus a host load port.
// After reset the array is swept to zero (one word per cycle); afterwards one
// access per cycle: a host write if requested, otherwise one round-robin read.
//   clk, reset          : clock and synchronous active-high reset
//   mem_read_valid      : per-channel read request (level)
//   mem_read_address    : flat per-channel word addresses
//   mem_read_ready      : per-channel one-cycle pulse, data slice valid
//   mem_read_data       : flat per-channel data, each slice held between pulses
//   host_write_*        : host load request / address / data, ready pulses on commit
//   init_done           : high once the clear sweep has finished
module program_memory_arb
    import prog_mem_pkg::*;
#(
    parameter int unsigned MEM_NUM_CHANNELS = 4,
    parameter int unsigned MEM_DATA_BITS    = 32,
    parameter int unsigned MEM_ADDR_BITS    = 6
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [MEM_NUM_CHANNELS-1:0]               mem_read_valid,
    input  logic [MEM_NUM_CHANNELS*MEM_ADDR_BITS-1:0] mem_read_address,
    output logic [MEM_NUM_CHANNELS-1:0]               mem_read_ready,
    output logic [MEM_NUM_CHANNELS*MEM_DATA_BITS-1:0] mem_read_data,
    input  logic                                      host_write_valid,
    input  logic [MEM_ADDR_BITS-1:0]                  host_write_address,
    input  logic [MEM_DATA_BITS-1:0]                  host_write_data,
    output logic                                      host_write_ready,
    output logic                                      init_done
);

    localparam int unsigned DEPTH = 2 ** MEM_ADDR_BITS;
    localparam int unsigned IW    = (MEM_NUM_CHANNELS > 1) ? $clog2(MEM_NUM_CHANNELS) : 1;

    pm_state_t                                 state_q, state_d;
    logic [MEM_ADDR_BITS-1:0]                  sweep_q, sweep_d;
    logic [IW-1:0]                             ptr_q, ptr_d;
    logic [MEM_NUM_CHANNELS-1:0]               ready_q, ready_d;
    logic [MEM_NUM_CHANNELS*MEM_DATA_BITS-1:0] data_q;
    logic                                      wr_ready_q, wr_ready_d;

    logic [MEM_DATA_BITS-1:0] mem_q [DEPTH];

    logic [MEM_NUM_CHANNELS-1:0] req;
    logic [MEM_NUM_CHANNELS-1:0] gnt;
    logic [IW-1:0]               gnt_idx;
    logic                        any_gnt;

    logic                     mem_we;
    logic [MEM_ADDR_BITS-1:0] wr_addr;
    logic [MEM_DATA_BITS-1:0] wr_data;
    logic                     rd_en;
    logic [MEM_ADDR_BITS-1:0] rd_addr;

    // A channel whose ready is high this cycle is masked so a held valid does
    // not trigger a duplicate fetch of the same request.
    assign req = mem_read_valid & ~ready_q;

    rr_arbiter #(
        .N  (MEM_NUM_CHANNELS),
        .IW (IW)
    ) u_arb (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_o     (gnt),
        .grant_idx_o (gnt_idx),
        .any_grant_o (any_gnt)
    );

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        ptr_d      = ptr_q;
        ready_d    = '0;
        wr_ready_d = 1'b0;
        mem_we     = 1'b0;
        wr_addr    = host_write_address;
        wr_data    = host_write_data;
        rd_en      = 1'b0;
        rd_addr    = mem_read_address[slice_lo(32'(gnt_idx), MEM_ADDR_BITS) +: MEM_ADDR_BITS];

        unique case (state_q)
            CLEAR: begin
                mem_we  = 1'b1;
                wr_addr = sweep_q;
                wr_data = '0;
                sweep_d = sweep_q + 1'b1;
                if (&sweep_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (host_write_valid) begin
                    mem_we     = 1'b1;
                    wr_ready_d = 1'b1;
                end else if (any_gnt) begin
                    rd_en   = 1'b1;
                    ready_d = gnt;
                    ptr_d   = (gnt_idx == IW'(MEM_NUM_CHANNELS - 1)) ? '0 : gnt_idx + IW'(1);
                end
            end
            default: state_d = CLEAR;
        endcase

        // No array write may slip through during a reset cycle.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            sweep_q    <= '0;
            ptr_q      <= '0;
            ready_q    <= '0;
            data_q     <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            ptr_q      <= ptr_d;
            ready_q    <= ready_d;
            wr_ready_q <= wr_ready_d;
            if (rd_en) begin
                data_q[slice_lo(32'(gnt_idx), MEM_DATA_BITS) +: MEM_DATA_BITS] <= mem_q[rd_addr];
            end
        end
    end

    assign mem_read_ready   = ready_q;
    assign mem_read_data    = data_q;
    assign host_write_ready = wr_ready_q;
    assign init_done        = (state_q == RUN);

endmodule

// File: tb/tb_program_memory_arb.sv
// Bench for program_memory_arb: behavioural model checked every cycle, a table
// of hand-derived vectors, and hand-written multi-cycle corner sequences.
module tb_program_memory_arb;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [NCH-1:0]      rv;
    logic [NCH*AW-1:0]   ra;
    logic [NCH-1:0]      rrdy;
    logic [NCH*DW-1:0]   rdata;
    logic                wv;
    logic [AW-1:0]       wa;
    logic [DW-1:0]       wd;
    logic                wrdy;
    logic                init_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [DW-1:0]     m_mem [DEPTH];
    int                m_cnt = 0;
    int                m_ptr = 0;
    logic [NCH-1:0]    m_rdy = '0;
    logic [NCH*DW-1:0] m_data = '0;
    logic              m_wrdy = 1'b0;

    always #5 clk = ~clk;

    program_memory_arb #(
        .MEM_NUM_CHANNELS (NCH),
        .MEM_DATA_BITS    (DW),
        .MEM_ADDR_BITS    (AW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_read_valid     (rv),
        .mem_read_address   (ra),
        .mem_read_ready     (rrdy),
        .mem_read_data      (rdata),
        .host_write_valid   (wv),
        .host_write_address (wa),
        .host_write_data    (wd),
        .host_write_ready   (wrdy),
        .init_done          (init_done)
    );

    task automatic check(input string name, input logic [NCH*DW-1:0] act,
                         input logic [NCH*DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock from the current inputs.
    task automatic model_step();
        int g;
        int c;
        g = -1;
        if (reset) begin
            m_cnt  = 0;
            m_ptr  = 0;
            m_rdy  = '0;
            m_data = '0;
            m_wrdy = 1'b0;
        end else if (m_cnt < DEPTH) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            m_rdy  = '0;
            m_wrdy = 1'b0;
        end else if (wv) begin
            m_mem[wa] = wd;
            m_wrdy    = 1'b1;
            m_rdy     = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                c = (m_ptr + i) % NCH;
                if (g < 0 && rv[c] && !m_rdy[c]) g = c;
            end
            m_wrdy = 1'b0;
            m_rdy  = '0;
            if (g >= 0) begin
                m_rdy[g] = 1'b1;
                m_data[g*DW +: DW] = m_mem[ra[g*AW +: AW]];
                m_ptr = (g + 1) % NCH;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model_ready", {124'd0, rrdy}, {124'd0, m_rdy});
        check("model_data", rdata, m_data);
        check("model_wr_ready", {127'd0, wrdy}, {127'd0, m_wrdy});
        check("model_init_done", {127'd0, init_done}, {127'd0, (m_cnt >= DEPTH)});
    endtask

    task automatic idle();
        rv = '0;
        ra = '0;
        wv = 1'b0;
        wa = '0;
        wd = '0;
    endtask

    typedef struct {
        logic [NCH-1:0]    rv;
        logic [NCH*AW-1:0] ra;
        logic              wv;
        logic [AW-1:0]     wa;
        logic [DW-1:0]     wd;
        logic [NCH-1:0]    e_rdy;
        logic              e_wrdy;
        logic [NCH*DW-1:0] e_data;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] dbe;
        int            pulses;
        logic          prev_rdy;
        dbe = 32'hDEADBEEF;

        tbl[0]  = '{4'b0000, 24'd0, 1'b1, 6'd5, dbe, 4'b0000, 1'b1, 128'd0};
        tbl[1]  = '{4'b0001, 24'd5, 1'b0, 6'd0, 32'd0, 4'b0001, 1'b0, {96'd0, dbe}};
        tbl[2]  = '{4'b1000, {6'd5, 18'd0}, 1'b0, 6'd0, 32'd0, 4'b1000, 1'b0,
                    {dbe, 64'd0, dbe}};
        tbl[3]  = '{4'b0000, 24'd0, 1'b1, 6'd1, 32'h11, 4'b0000, 1'b1, {dbe, 64'd0, dbe}};
        tbl[4]  = '{4'b0000, 24'd0, 1'b1, 6'd2, 32'h22, 4'b0000, 1'b1, {dbe, 64'd0, dbe}};
        tbl[5]  = '{4'b0000, 24'd0, 1'b1, 6'd3, 32'h33, 4'b0000, 1'b1, {dbe, 64'd0, dbe}};
        tbl[6]  = '{4'b0000, 24'd0, 1'b1, 6'd4, 32'h44, 4'b0000, 1'b1, {dbe, 64'd0, dbe}};
        tbl[7]  = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 6'd0, 32'd0, 4'b0001, 1'b0,
                    {dbe, 32'h0, 32'h0, 32'h11}};
        tbl[8]  = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 6'd0, 32'd0, 4'b0010, 1'b0,
                    {dbe, 32'h0, 32'h22, 32'h11}};
        tbl[9]  = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 6'd0, 32'd0, 4'b0100, 1'b0,
                    {dbe, 32'h33, 32'h22, 32'h11}};
        tbl[10] = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 6'd0, 32'd0, 4'b1000, 1'b0,
                    {32'h44, 32'h33, 32'h22, 32'h11}};
        tbl[11] = '{4'b0000, 24'd0, 1'b0, 6'd0, 32'd0, 4'b0000, 1'b0,
                    {32'h44, 32'h33, 32'h22, 32'h11}};

        // Reset
        idle();
        reset = 1'b1;
        repeat (3) cycle();
        check("rst_ready", {124'd0, rrdy}, 128'd0);
        check("rst_data", rdata, 128'd0);
        check("rst_wr_ready", {127'd0, wrdy}, 128'd0);
        check("rst_init_done", {127'd0, init_done}, 128'd0);
        reset = 1'b0;

        // Clear sweep: init_done rises exactly DEPTH cycles after reset release
        for (int k = 1; k <= DEPTH; k++) begin
            cycle();
            check("init_edge", {127'd0, init_done}, {127'd0, (k == DEPTH)});
        end

        // Every address reads back zero on ch0
        for (int a = 0; a < DEPTH; a++) begin
            rv = 4'b0001;
            ra = '0;
            ra[AW-1:0] = AW'(a);
            cycle();
            check("clr_rd_ready", {124'd0, rrdy}, 128'd1);
            check("clr_rd_data", {96'd0, rdata[DW-1:0]}, 128'd0);
            rv = '0;
            cycle();
        end

        // Table: write/read-back, preload, all-channel round robin
        for (int i = 0; i < 12; i++) begin
            rv = tbl[i].rv;
            ra = tbl[i].ra;
            wv = tbl[i].wv;
            wa = tbl[i].wa;
            wd = tbl[i].wd;
            cycle();
            check("tbl_ready", {124'd0, rrdy}, {124'd0, tbl[i].e_rdy});
            check("tbl_wr_ready", {127'd0, wrdy}, {127'd0, tbl[i].e_wrdy});
            check("tbl_data", rdata, tbl[i].e_data);
        end

        // Held host write starves ch1 for three cycles
        idle();
        rv = 4'b0010;
        ra[2*AW-1:AW] = 6'd2;
        wv = 1'b1;
        wa = 6'd10;
        wd = 32'hA5A5_0001;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("starve_wr_ready", {127'd0, wrdy}, 128'd1);
            check("starve_ready", {124'd0, rrdy}, 128'd0);
        end
        wv = 1'b0;
        cycle();
        check("starve_gnt_ready", {124'd0, rrdy}, 128'b0010);
        check("starve_gnt_data", {96'd0, rdata[2*DW-1:DW]}, 128'h22);
        check("starve_gnt_wr", {127'd0, wrdy}, 128'd0);
        rv = '0;
        cycle();

        // ch2 holds valid: ready every other cycle
        rv = 4'b0100;
        ra = '0;
        ra[3*AW-1:2*AW] = 6'd3;
        pulses   = 0;
        prev_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("alt_ready", {127'd0, rrdy[2]}, {127'd0, (k % 2 == 0)});
            check("alt_no_b2b", {127'd0, (prev_rdy & rrdy[2])}, 128'd0);
            prev_rdy = rrdy[2];
            if (rrdy[2]) pulses++;
        end
        check("alt_pulses", 128'(pulses), 128'd5);
        idle();
        cycle();

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 999) == 0);
            rv = NCH'($urandom);
            ra = (NCH*AW)'($urandom);
            wv = ($urandom_range(0, 3) == 0);
            wa = AW'($urandom);
            wd = $urandom;
            cycle();
        end
        reset = 1'b0;

        // Reset mid-operation with a ch0 read pending
        idle();
        rv = 4'b0001;
        ra[AW-1:0] = 6'd5;
        reset = 1'b1;
        cycle();
        check("mid_rst_ready", {124'd0, rrdy}, 128'd0);
        check("mid_rst_data", rdata, 128'd0);
        check("mid_rst_init", {127'd0, init_done}, 128'd0);
        reset = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            cycle();
            check("mid_pend_ready", {124'd0, rrdy}, 128'd0);
        end
        cycle();
        check("mid_served_ready", {124'd0, rrdy}, 128'd1);
        check("mid_served_data", {96'd0, rdata[DW-1:0]}, 128'd0);
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
